// File: rtl/arm_instr_encoder_if.sv
// ============================================================================
//  Module  : arm_instr_encoder_if
//  Purpose : Request/response bundle for the ARM instruction encoder.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface arm_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_class;
  logic [3:0]  in_cond;
  logic        in_imm;
  logic [3:0]  in_cmd;
  logic        in_s;
  logic [3:0]  in_rn;
  logic [3:0]  in_rd;
  logic [11:0] in_op2;
  logic        in_link;
  logic [23:0] in_boff;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;

  modport master (
    output in_valid, in_class, in_cond, in_imm, in_cmd, in_s, in_rn, in_rd,
           in_op2, in_link, in_boff, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err
  );

  modport slave (
    input  in_valid, in_class, in_cond, in_imm, in_cmd, in_s, in_rn, in_rd,
           in_op2, in_link, in_boff, out_ready,
    output in_ready, out_valid, out_instr, out_addr, err
  );
endinterface

`default_nettype wire

// File: rtl/arm_instr_encoder.sv
// ============================================================================
//  Module  : arm_instr_encoder
//  Purpose : Encodes DP/memory/branch requests into 32-bit ARM words through a
//            2-entry output buffer with a running imem byte address.
//            Define ARM_ENC_BRL_EN to allow branch-with-link.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module arm_instr_encoder (
  input  wire logic            clk,
  input  wire logic            reset,
  arm_instr_encoder_if.slave   bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_head;
  logic [31:0] r_tail;
  logic [31:0] r_addr;
  logic        r_err;

  logic [31:0] w_enc;
  logic        w_illegal;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;

  always_comb begin
    w_enc = '0;
    case (bus.in_class)
      2'b00:   w_enc = {bus.in_cond, 2'b00, bus.in_imm, bus.in_cmd, bus.in_s,
                        bus.in_rn, bus.in_rd, bus.in_op2};
      2'b01:   w_enc = {bus.in_cond, 2'b01, ~bus.in_imm, 4'b1100, bus.in_s,
                        bus.in_rn, bus.in_rd, bus.in_op2};
      2'b10:   w_enc = {bus.in_cond, 3'b101, bus.in_link, bus.in_boff};
      default: w_enc = '0;
    endcase
  end

`ifdef ARM_ENC_BRL_EN
  assign w_illegal = (bus.in_class == 2'b11);
`else
  // Without link support a BL request is rejected like an illegal class.
  assign w_illegal = (bus.in_class == 2'b11) ||
                     ((bus.in_class == 2'b10) && bus.in_link);
`endif

  assign bus.in_ready  = !reset && (r_state != S_TWO);
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign w_push        = w_accept && !w_illegal;
  assign w_pop         = (r_state != S_EMPTY) && bus.out_ready;

  assign bus.out_valid = (r_state != S_EMPTY);
  assign bus.out_instr = r_head;
  assign bus.out_addr  = r_addr;
  assign bus.err       = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
      r_addr  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_accept && w_illegal;
      if (w_pop) begin
        r_addr <= r_addr + 32'd4;
      end
      case (r_state)
        S_EMPTY: begin
          if (w_push) begin
            r_head  <= w_enc;
            r_state <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_push && w_pop) begin
            r_head <= w_enc;
          end else if (w_push) begin
            r_tail  <= w_enc;
            r_state <= S_TWO;
          end else if (w_pop) begin
            r_state <= S_EMPTY;
          end
        end
        S_TWO: begin
          // in_ready is low here, so only a pop can occur.
          if (w_pop) begin
            r_head  <= r_tail;
            r_state <= S_ONE;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arm_instr_encoder.sv
// ============================================================================
//  Module  : tb_arm_instr_encoder
//  Purpose : Self-checking bench: queue-based reference model plus literal
//            expectations for arm_instr_encoder.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_arm_instr_encoder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arm_instr_encoder_if bus ();

  arm_instr_encoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit check_en = 1'b0;

  logic [31:0] mq[$];
  logic [31:0] m_addr = '0;
  bit          m_err  = 1'b0;
  bit          m_acc, m_pop, m_ill;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] model_enc(
      input logic [1:0] cls, input logic [3:0] cond, input logic imm,
      input logic [3:0] cmd, input logic s, input logic [3:0] rn,
      input logic [3:0] rd, input logic [11:0] op2, input logic link,
      input logic [23:0] boff);
    logic [31:0] w;
    w = 32'(cond) << 28;
    if (cls == 2'd0)
      w = w | (32'(imm) << 25) | (32'(cmd) << 21) | (32'(s) << 20)
            | (32'(rn) << 16) | (32'(rd) << 12) | 32'(op2);
    else if (cls == 2'd1)
      w = w | (32'd1 << 26) | (32'(!imm) << 25) | (32'd12 << 21) | (32'(s) << 20)
            | (32'(rn) << 16) | (32'(rd) << 12) | 32'(op2);
    else
      w = w | (32'd5 << 25) | (32'(link) << 24) | 32'(boff);
    return w;
  endfunction

  function automatic bit model_illegal(input logic [1:0] cls, input logic link);
`ifdef ARM_ENC_BRL_EN
    return (cls == 2'd3);
`else
    return (cls == 2'd3) || (cls == 2'd2 && link);
`endif
  endfunction

  // Reference model: occupancy-limited queue and a byte address counter.
  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_addr = '0;
      m_err  = 1'b0;
    end else begin
      m_acc = bus.in_valid && (mq.size() < 2);
      m_pop = (mq.size() > 0) && bus.out_ready;
      m_ill = model_illegal(bus.in_class, bus.in_link);
      m_err = m_acc && m_ill;
      if (m_pop) begin
        void'(mq.pop_front());
        m_addr = m_addr + 32'd4;
      end
      if (m_acc && !m_ill)
        mq.push_back(model_enc(bus.in_class, bus.in_cond, bus.in_imm, bus.in_cmd,
                               bus.in_s, bus.in_rn, bus.in_rd, bus.in_op2,
                               bus.in_link, bus.in_boff));
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("in_ready", 32'(bus.in_ready), 32'(!reset && (mq.size() < 2)));
      chk("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
      chk("err", 32'(bus.err), 32'(m_err));
      chk("out_addr", bus.out_addr, m_addr);
      if (mq.size() > 0) chk("out_instr", bus.out_instr, mq[0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drive(input logic [1:0] cls, input logic [3:0] cond, input logic imm,
                       input logic [3:0] cmd, input logic s, input logic [3:0] rn,
                       input logic [3:0] rd, input logic [11:0] op2, input logic link,
                       input logic [23:0] boff);
    bus.in_valid = 1'b1;
    bus.in_class = cls;
    bus.in_cond  = cond;
    bus.in_imm   = imm;
    bus.in_cmd   = cmd;
    bus.in_s     = s;
    bus.in_rn    = rn;
    bus.in_rd    = rd;
    bus.in_op2   = op2;
    bus.in_link  = link;
    bus.in_boff  = boff;
  endtask

  task automatic drv_dp();
    drive(2'd0, 4'hE, 1'b1, 4'b0100, 1'b0, 4'd1, 4'd2, 12'h005, 1'b0, 24'h0);
  endtask

  task automatic drv_mem();
    drive(2'd1, 4'hE, 1'b1, 4'd0, 1'b1, 4'd0, 4'd3, 12'h004, 1'b0, 24'h0);
  endtask

  task automatic drv_br(input logic link, input logic [23:0] boff);
    drive(2'd2, 4'hE, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 12'h0, link, boff);
  endtask

  // Hold a request until the DUT takes it, with random output backpressure.
  task automatic send_rand(input logic [1:0] cls);
    bit ok;
    drive(cls, 4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
          4'($urandom), 12'($urandom), 1'($urandom), 24'($urandom));
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bus.out_ready = (k % 2 == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    step();
    idle();
    if (!ok) begin
      n_total++;
      $display("FAIL send_timeout: in_ready never rose, expected acceptance within 20 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.out_ready = 1'b0;
    drive(2'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 12'd0, 1'b0, 24'd0);
    idle();
    step();
    check_en = 1'b1;
    step();
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_out_addr", bus.out_addr, 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    step();
    reset = 1'b0;

    // Single words with no backpressure
    bus.out_ready = 1'b1;
    drv_dp(); step(); idle();
    @(negedge clk);
    chk("dp_instr", bus.out_instr, 32'hE2812005);
    chk("dp_addr", bus.out_addr, 32'h0);
    step();
    drv_mem(); step(); idle();
    @(negedge clk);
    chk("mem_instr", bus.out_instr, 32'hE5903004);
    chk("mem_addr", bus.out_addr, 32'h4);
    step();
    drv_br(1'b0, 24'hFFFFFE); step(); idle();
    @(negedge clk);
    chk("br_instr", bus.out_instr, 32'hEAFFFFFE);
    chk("br_addr", bus.out_addr, 32'h8);
    step();

    // Illegal class
    drive(2'd3, 4'hE, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 12'h0, 1'b0, 24'h0);
    step(); idle();
    @(negedge clk);
    chk("ill_err", 32'(bus.err), 32'd1);
    chk("ill_valid", 32'(bus.out_valid), 32'd0);
    step();
    @(negedge clk);
    chk("ill_err_clr", 32'(bus.err), 32'd0);
    chk("ill_addr", bus.out_addr, 32'hC);
    step();

    // Branch with link
    drv_br(1'b1, 24'h000002); step(); idle();
    @(negedge clk);
`ifdef ARM_ENC_BRL_EN
    chk("bl_instr", bus.out_instr, 32'hEB000002);
    chk("bl_valid", 32'(bus.out_valid), 32'd1);
`else
    chk("bl_err", 32'(bus.err), 32'd1);
    chk("bl_valid", 32'(bus.out_valid), 32'd0);
`endif
    step();

    // Backpressure from a fresh reset
    reset = 1'b1; step(); reset = 1'b0;
    bus.out_ready = 1'b0;
    drv_dp(); step();
    drv_mem(); step();
    drv_br(1'b0, 24'h000010);
    @(negedge clk);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_head", bus.out_instr, 32'hE2812005);
    repeat (3) step();
    @(negedge clk);
    chk("bp_hold_instr", bus.out_instr, 32'hE2812005);
    chk("bp_hold_addr", bus.out_addr, 32'h0);
    step();
    idle();
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_drain0_instr", bus.out_instr, 32'hE2812005);
    chk("bp_drain0_addr", bus.out_addr, 32'h0);
    step();
    @(negedge clk);
    chk("bp_drain1_instr", bus.out_instr, 32'hE5903004);
    chk("bp_drain1_addr", bus.out_addr, 32'h4);
    step();
    @(negedge clk);
    chk("bp_empty", 32'(bus.out_valid), 32'd0);
    chk("bp_final_addr", bus.out_addr, 32'h8);

    // Reset while the buffer is full
    step();
    bus.out_ready = 1'b0;
    drv_dp(); step();
    drv_mem(); step();
    idle();
    reset = 1'b1; step(); reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    step();
    bus.out_ready = 1'b1;
    drv_br(1'b0, 24'hFFFFFE); step(); idle();
    @(negedge clk);
    chk("mid_rst_instr", bus.out_instr, 32'hEAFFFFFE);
    chk("mid_rst_addr", bus.out_addr, 32'h0);
    step();

    // Mixed classes under random backpressure, checked by the model
    for (int i = 0; i < 16; i++) send_rand(2'(i % 4));
    bus.out_ready = 1'b1;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/arm_instr_encoder.md
ARM_INSTR_ENCODER -- requirements
Module: arm_instr_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high.
REQ-003 SHALL have ports: in_valid  in  1  request present; in_ready  out  1  request accepted when in_valid&&in_ready.
REQ-004 SHALL have ports: in_class  in  2  00 data-processing, 01 memory, 10 branch, 11 illegal.
REQ-005 SHALL have ports: in_cond  in  4  condition field; in_imm  in  1  immediate operand select; in_cmd  in  4  ALU cmd; in_s  in  1  S bit (DP) or L bit (memory).
REQ-006 SHALL have ports: in_rn  in  4; in_rd  in  4; in_op2  in  12  Src2/offset field; in_link  in  1  branch-with-link; in_boff  in  24  branch word offset.
REQ-007 SHALL have ports: out_valid  out  1; out_ready  in  1; out_instr  out  32  encoded word; out_addr  out  32  imem byte address for out_instr.
REQ-008 SHALL have ports: err  out  1  one-cycle pulse, request dropped.

Function
REQ-009 SHALL encode all classes as [31:28]=in_cond.
REQ-010 SHALL encode DP as [27:26]=00, [25]=in_imm, [24:21]=in_cmd, [20]=in_s, [19:16]=in_rn, [15:12]=in_rd, [11:0]=in_op2.
REQ-011 SHALL encode memory as [27:26]=01, [25]=~in_imm, [24:21]=1100 (P=1,U=1,B=0,W=0), [20]=in_s, [19:16]=in_rn, [15:12]=in_rd, [11:0]=in_op2.
REQ-012 SHALL encode branch as [27:25]=101, [24]=in_link, [23:0]=in_boff.
REQ-013 SHALL register encoding into a 2-entry FIFO output buffer; FSM states EMPTY, ONE, TWO by occupancy.
REQ-014 SHALL drive in_ready=1 in EMPTY and ONE, 0 in TWO.
REQ-015 SHALL present a request accepted in cycle N on out_instr in cycle N+1 when buffer was EMPTY (latency 1).
REQ-016 SHALL hold out_instr/out_addr stable while out_valid&&!out_ready.
REQ-017 SHALL transition EMPTY->ONE on push; ONE->TWO push only; ONE->EMPTY pop only; ONE stays ONE on push+pop; TWO->ONE on pop.
REQ-018 SHALL keep a 32-bit address counter, out_addr=counter, counter+=4 on each out_valid&&out_ready, wrapping 0xFFFFFFFC->0x00000000.
REQ-019 SHALL accept in_class=11 (when in_ready), not buffer it, and pulse err the following cycle.
REQ-020 SHALL preserve order: out_instr emerges in acceptance order.

Reset
REQ-021 SHALL on reset: state EMPTY, out_valid=0, out_instr=0, out_addr=0, counter=0, err=0, in_ready=0 during reset cycle.
REQ-022 SHALL discard buffered words when reset asserts mid-operation; first post-reset output uses out_addr=0.

Configuration
REQ-023 SHALL support macro ARM_ENC_BRL_EN.
REQ-024 SHALL with ARM_ENC_BRL_EN defined encode branch [24]=in_link per REQ-012.
REQ-025 SHALL without ARM_ENC_BRL_EN treat branch with in_link=1 as illegal per REQ-019; in_link=0 branches encode normally.

Verification
REQ-026 DP: cond=E, imm=1, cmd=0100, s=0, rn=1, rd=2, op2=0x005, out_ready=1 -> next cycle out_instr=0xE2812005, out_addr=0.
REQ-027 Memory: cond=E, imm=1, s=1, rn=0, rd=3, op2=0x004 -> out_instr=0xE5903004; branch cond=E, link=0, boff=0xFFFFFE -> 0xEAFFFFFE.
REQ-028 Backpressure: out_ready=0, push 3 requests -> two accepted, in_ready=0 after 2nd; release -> both drained in order, out_addr 0 then 4.
REQ-029 Illegal: in_class=11 accepted -> err=1 one cycle, out_valid unchanged, counter unchanged.
REQ-030 BL: cond=E, link=1, boff=0x000002 -> 0xEB000002 with ARM_ENC_BRL_EN; err pulse and no output without it.
REQ-031 Reset mid-stream: buffer in TWO, reset 1 cycle -> out_valid=0; next accepted request emerges with out_addr=0.
